// File: rtl/spike_pkg.sv
// Shared definitions for the spike-processing block family: the decoder FSM
// state encoding, the default counter width and a saturating increment.
package spike_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Add one unless already at all-ones; the caller detects saturation separately.
    function automatic logic [CNT_W_DEF-1:0] sat_inc8(input logic [CNT_W_DEF-1:0] v);
        return (v == {CNT_W_DEF{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result handshake bundle of the rate decoder: the producer drives the rate
// and its valid flag, the consumer drives ready.
interface spike_rate_if
    import spike_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic [CNT_W-1:0] rate;
    logic             rate_valid;
    logic             rate_ready;

    modport master (output rate, output rate_valid, input rate_ready);
    modport slave  (input rate, input rate_valid, output rate_ready);
endinterface

// File: rtl/spike_rate_decoder_window_timer.sv
// Window countdown: loaded with the window length (0 means 2^CNT_W) and
// decremented once per counting cycle; flags the final cycle of the window.
module window_timer
    import spike_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] length,
    input  logic             tick,
    output logic             last_cycle
);

    // One extra bit so that a length of 2^CNT_W is representable.
    logic [CNT_W:0] r_remain;
    logic [CNT_W:0] w_load_val;

    assign w_load_val = (length == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, length};

    // Remaining-cycles counter: load at window start, count down while counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remain <= '0;
        end else if (load) begin
            r_remain <= w_load_val;
        end else if (tick && (r_remain != '0)) begin
            r_remain <= r_remain - 1'b1;
        end
    end

    assign last_cycle = (r_remain == (CNT_W+1)'(1));

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes over a programmable window, presents the
// count on a valid/ready result port and optionally restarts automatically.
module spike_rate_decoder
    import spike_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] window_len,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             busy,
    output logic             overflow,
    output logic             missed
);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_valid;
    logic             r_overflow;
    logic             r_missed;

    logic             w_handshake;
    logic             w_load;
    logic             w_tick;
    logic             w_last;
    logic [CNT_W-1:0] w_count_next;
    logic             w_sat_hit;

    // Window start comes either from IDLE+start or from a result handshake in
    // continuous mode; in both cases the loading cycle samples no spike.
    always_comb begin
        w_handshake  = (r_state == ST_HOLD) && r_rate_valid && rate_ready;
        w_load       = ((r_state == ST_IDLE) && start) || (w_handshake && cont);
        w_tick       = (r_state == ST_COUNT);
        w_sat_hit    = spike_in && (r_count == {CNT_W{1'b1}});
        w_count_next = r_count;
        if (spike_in && !w_sat_hit) begin
            w_count_next = r_count + 1'b1;
        end
    end

    window_timer #(
        .CNT_W (CNT_W)
    ) u_window_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .length     (window_len),
        .tick       (w_tick),
        .last_cycle (w_last)
    );

    // Control FSM with registered result, flags and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_missed     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_COUNT;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_missed   <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    r_count <= w_count_next;
                    if (w_sat_hit) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_last) begin
                        r_rate       <= w_count_next;
                        r_rate_valid <= 1'b1;
                        r_state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Counting is blocked here, so any spike is lost.
                    if (spike_in) begin
                        r_missed <= 1'b1;
                    end
                    if (w_handshake) begin
                        r_rate_valid <= 1'b0;
                        if (cont) begin
                            r_state    <= ST_COUNT;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign busy       = (r_state == ST_COUNT);
    assign overflow   = r_overflow;
    assign missed     = r_missed;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: linear scenario steps with
// hand-computed expectations checked by immediate assertions.
module tb_spike_rate_decoder;
    import spike_pkg::*;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             spike_in;
    logic [CNT_W-1:0] window_len;
    logic             start;
    logic             cont;
    logic             busy;
    logic             overflow;
    logic             missed;

    int n_cmp;
    int n_fail;

    spike_rate_if #(.CNT_W(CNT_W)) u_if ();

    spike_rate_decoder #(
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spike_in   (spike_in),
        .window_len (window_len),
        .start      (start),
        .cont       (cont),
        .rate       (u_if.rate),
        .rate_valid (u_if.rate_valid),
        .rate_ready (u_if.rate_ready),
        .busy       (busy),
        .overflow   (overflow),
        .missed     (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        spike_in = 1'b0;
        window_len = 8'd0;
        start = 1'b0;
        cont = 1'b0;
        u_if.rate_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rate", int'(u_if.rate), 0);
        chk("rst_valid", int'(u_if.rate_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_missed", int'(missed), 0);

        // Window of 10, spikes on odd cycles 1..9 -> rate 5 at cycle 11
        window_len = 8'd10;
        start = 1'b1;
        tick();                       // now cycle 1
        start = 1'b0;
        chk("w10_busy_c1", int'(busy), 1);
        for (int c = 1; c <= 10; c++) begin
            spike_in = (c % 2 == 1);
            if (c == 10) chk("w10_valid_c10", int'(u_if.rate_valid), 0);
            tick();
        end
        spike_in = 1'b0;
        chk("w10_rate", int'(u_if.rate), 5);
        chk("w10_valid", int'(u_if.rate_valid), 1);
        chk("w10_ovf", int'(overflow), 0);
        chk("w10_busy_hold", int'(busy), 0);
        u_if.rate_ready = 1'b1;
        tick();
        u_if.rate_ready = 1'b0;
        chk("w10_valid_after_hs", int'(u_if.rate_valid), 0);
        chk("w10_rate_kept", int'(u_if.rate), 5);

        // HOLD back-pressure with spikes -> missed; start ignored in HOLD
        window_len = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        spike_in = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("hold_rate", int'(u_if.rate), 3);
        chk("hold_missed0", int'(missed), 0);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            start = 1'b0;
            chk("hold_rate_stable", int'(u_if.rate), 3);
            chk("hold_valid", int'(u_if.rate_valid), 1);
            chk("hold_missed", int'(missed), 1);
        end
        spike_in = 1'b0;
        u_if.rate_ready = 1'b1;
        tick();
        u_if.rate_ready = 1'b0;
        chk("hold_exit_busy", int'(busy), 0);
        chk("hold_exit_valid", int'(u_if.rate_valid), 0);
        chk("hold_missed_kept", int'(missed), 1);
        tick();
        chk("idle_missed_kept", int'(missed), 1);

        // Window length 0 -> 256 cycles, saturation to 255 with overflow
        window_len = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("w256_missed_cleared", int'(missed), 0);
        spike_in = 1'b1;
        for (int c = 0; c < 255; c++) tick();
        chk("w256_busy_c256", int'(busy), 1);
        chk("w256_valid_c256", int'(u_if.rate_valid), 0);
        tick();
        spike_in = 1'b0;
        chk("w256_rate", int'(u_if.rate), 255);
        chk("w256_ovf", int'(overflow), 1);
        chk("w256_valid", int'(u_if.rate_valid), 1);
        u_if.rate_ready = 1'b1;
        tick();
        u_if.rate_ready = 1'b0;
        spike_in = 1'b1;              // spike in IDLE must be ignored
        tick();
        spike_in = 1'b0;
        chk("idle_spike_no_missed", int'(missed), 0);
        chk("idle_busy", int'(busy), 0);

        // Continuous mode: two back-to-back windows of 4
        cont = 1'b1;
        window_len = 8'd4;
        spike_in = 1'b1;
        u_if.rate_ready = 1'b1;
        start = 1'b1;
        tick();                       // cycle 1
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();   // cycle 5: HOLD
        chk("cont_rate1", int'(u_if.rate), 4);
        chk("cont_valid1", int'(u_if.rate_valid), 1);
        chk("cont_ovf", int'(overflow), 0);
        tick();                       // cycle 6: COUNT again
        chk("cont_busy_restart", int'(busy), 1);
        chk("cont_valid_cleared", int'(u_if.rate_valid), 0);
        for (int c = 0; c < 4; c++) tick();   // cycle 10: HOLD
        chk("cont_rate2", int'(u_if.rate), 4);
        chk("cont_valid2", int'(u_if.rate_valid), 1);
        cont = 1'b0;
        tick();
        chk("cont_stop_busy", int'(busy), 0);
        chk("cont_stop_valid", int'(u_if.rate_valid), 0);
        u_if.rate_ready = 1'b0;
        spike_in = 1'b0;

        // Reset in the 3rd COUNT cycle
        window_len = 8'd8;
        spike_in = 1'b1;
        start = 1'b1;
        tick();                       // cycle 1
        start = 1'b0;
        tick();                       // cycle 2
        tick();                       // cycle 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rate", int'(u_if.rate), 0);
        chk("mid_rst_valid", int'(u_if.rate_valid), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_missed", int'(missed), 0);
        window_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("post_rst_rate", int'(u_if.rate), 2);
        chk("post_rst_valid", int'(u_if.rate_valid), 1);
        spike_in = 1'b0;
        u_if.rate_ready = 1'b1;
        tick();
        u_if.rate_ready = 1'b0;

        // Mid-window start and window_len change have no effect
        window_len = 8'd6;
        spike_in = 1'b1;
        start = 1'b1;
        tick();                       // cycle 1
        start = 1'b0;
        tick();                       // cycle 2
        start = 1'b1;
        window_len = 8'd3;
        tick();                       // cycle 3
        start = 1'b0;
        tick();                       // cycle 4
        chk("nochg_busy_c4", int'(busy), 1);
        chk("nochg_valid_c4", int'(u_if.rate_valid), 0);
        tick();
        tick();
        tick();                       // cycle 7: HOLD
        spike_in = 1'b0;
        chk("nochg_rate", int'(u_if.rate), 6);
        chk("nochg_valid", int'(u_if.rate_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, meaning width of the spike count, rate and window length.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port spike_in  input  1  spike train from a neuron; sampled once per clk.
REQ-005 SHALL have port window_len  input  CNT_W  window length in cycles; 0 encodes 2^CNT_W.
REQ-006 SHALL have port start  input  1  request to begin one counting window.
REQ-007 SHALL have port cont  input  1  auto-restart a new window after each result handshake.
REQ-008 SHALL have port rate  output  CNT_W  spikes counted in the last completed window.
REQ-009 SHALL have port rate_valid  output  1  rate holds an unconsumed result.
REQ-010 SHALL have port rate_ready  input  1  consumer accepts rate when high together with rate_valid.
REQ-011 SHALL have port busy  output  1  high while a window is being counted.
REQ-012 SHALL have port overflow  output  1  the last window's count saturated.
REQ-013 SHALL have port missed  output  1  sticky: a spike arrived while HOLD blocked counting.

Function
REQ-014 SHALL implement states IDLE, COUNT, HOLD; busy = (state == COUNT).
REQ-015 IDLE: start=1 SHALL move to COUNT next cycle, clear count and overflow, and load the window counter from window_len (0 -> 2^CNT_W).
REQ-016 window_len SHALL be captured only when a window starts; changes mid-window have no effect.
REQ-017 COUNT SHALL last exactly N cycles (N = loaded length), sampling spike_in once in each cycle; the cycle in which start is accepted samples nothing.
REQ-018 count SHALL increment by 1 per sampled spike, saturating at 2^CNT_W-1; a spike at saturation sets overflow.
REQ-019 In the last COUNT cycle the final count, including that cycle's spike, SHALL be written to rate; the FSM then enters HOLD with rate_valid=1 on the next cycle.
REQ-020 rate and overflow SHALL stay stable throughout HOLD.
REQ-021 HOLD SHALL exit on rate_valid && rate_ready: to IDLE if cont=0; if cont=1, directly to COUNT, reloading window_len with the handshake cycle as the non-sampling cycle.
REQ-022 A spike_in=1 while in HOLD SHALL set missed; missed SHALL clear only on reset or on the next start accepted from IDLE.
REQ-023 spike_in in IDLE SHALL be ignored and SHALL NOT set missed.
REQ-024 start SHALL be ignored in COUNT and HOLD.
REQ-025 rate SHALL keep its last value after the handshake until the next window completes.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, count=0, window counter=0, rate=0, rate_valid=0, busy=0, overflow=0, missed=0; this applies from any state, mid-window included.
REQ-027 The first start after rst deasserts SHALL behave exactly as per REQ-015.

Structure
REQ-028 The state enum and default CNT_W SHALL be defined in shared package spike_pkg, which the lif-family blocks also use.
REQ-029 The window countdown SHALL be a sub-module window_timer (load, length, tick, last_cycle); count, rate and FSM stay in the top module.

Verification
REQ-030 window_len=10; start at cycle 0; spike_in=1 on odd cycles 1..9 -> rate=5 and rate_valid=1 at cycle 11; overflow=0.
REQ-031 window_len=0; spike_in held at 1 -> after 256 COUNT cycles rate=255 and overflow=1.
REQ-032 Completed window; rate_ready=0 for 5 cycles with spike_in=1 -> rate stable, missed=1; then rate_ready=1 -> IDLE next cycle, missed stays 1 until the next start.
REQ-033 cont=1, window_len=4, spike_in=1, rate_ready=1 -> two consecutive results of rate=4, with only the handshake cycle between windows.
REQ-034 rst pulsed in the 3rd COUNT cycle -> next cycle all outputs 0 and state IDLE; a following start with window_len=2 and spike_in=1 yields rate=2.
REQ-035 start pulsed and window_len changed to 3 during a window_len=6 window -> no restart, window ends after 6 cycles.
